// File: rtl/icache_pkg.sv
// Geometry constants and state type shared by the direct-mapped instruction cache.
package icache_pkg;

  localparam int unsigned ICLN   = 4;
  localparam int unsigned ICLLEN = 128;
  localparam int unsigned ILEN   = 32;
  localparam int unsigned XLEN   = 32;

  localparam int unsigned ICOFF_W = $clog2(ICLLEN / 8);
  localparam int unsigned ICIDX_W = $clog2(ICLN);
  localparam int unsigned ICTAG_W = XLEN - ICIDX_W - ICOFF_W;
  localparam int unsigned ICWORDS = ICLLEN / ILEN;

  // Word-select width within a line and byte-offset width within an instruction.
  localparam int unsigned ICWSEL_W  = $clog2(ICWORDS);
  localparam int unsigned INSTR_B_W = $clog2(ILEN / 8);

  typedef enum logic [1:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT} ic_state_t;

endpackage

// File: rtl/icache_if.sv
// Fetch-side request/response and memory-side refill signals of the instruction cache.
interface icache_if;

  logic                             req_valid;
  logic [icache_pkg::XLEN-1:0]      req_addr;
  logic                             req_ready;
  logic                             resp_valid;
  logic [icache_pkg::ILEN-1:0]      resp_instr;
  logic                             invalidate;
  logic                             mem_req_valid;
  logic [icache_pkg::XLEN-1:0]      mem_req_addr;
  logic                             mem_req_ready;
  logic                             mem_resp_valid;
  logic [icache_pkg::ICLLEN-1:0]    mem_resp_data;

  modport slave (
    input  req_valid, req_addr, invalidate, mem_req_ready, mem_resp_valid, mem_resp_data,
    output req_ready, resp_valid, resp_instr, mem_req_valid, mem_req_addr
  );

  modport master (
    output req_valid, req_addr, invalidate, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  req_ready, resp_valid, resp_instr, mem_req_valid, mem_req_addr
  );

endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache: single-cycle hit path, whole-line refill on miss.
module icache
  import icache_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  icache_if.slave  bus
);

  ic_state_t                state;
  logic [XLEN-1:INSTR_B_W]  pend_addr;
  logic [ICLN-1:0]          valid;
  logic [ICTAG_W-1:0]       tag_q  [ICLN];
  logic [ICLLEN-1:0]        data_q [ICLN];

  logic [ICIDX_W-1:0]       idx;
  logic [ICTAG_W-1:0]       tag;
  logic [ICWSEL_W-1:0]      wsel;
  logic                     hit;
  logic                     refill;

  always_comb begin
    idx    = pend_addr[ICOFF_W +: ICIDX_W];
    tag    = pend_addr[XLEN-1 -: ICTAG_W];
    wsel   = pend_addr[INSTR_B_W +: ICWSEL_W];
    hit    = (state == LOOKUP) && valid[idx] && (tag_q[idx] == tag);
    refill = (state == MISS_WAIT) && bus.mem_resp_valid;
  end

  always_comb begin
    bus.req_ready     = 1'b0;
    bus.resp_valid    = 1'b0;
    bus.resp_instr    = '0;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_addr  = '0;
    if (!rst) begin
      unique case (state)
        IDLE: bus.req_ready = 1'b1;
        LOOKUP: begin
          if (hit) begin
            bus.req_ready  = 1'b1;
            bus.resp_valid = 1'b1;
            bus.resp_instr = data_q[idx][ILEN*wsel +: ILEN];
          end
        end
        MISS_REQ: begin
          bus.mem_req_valid = 1'b1;
          bus.mem_req_addr  = {pend_addr[XLEN-1:ICOFF_W], {ICOFF_W{1'b0}}};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      valid <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            pend_addr <= bus.req_addr[XLEN-1:INSTR_B_W];
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (bus.req_valid) pend_addr <= bus.req_addr[XLEN-1:INSTR_B_W];
            else               state     <= IDLE;
          end else begin
            state <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          if (bus.mem_req_ready) state <= MISS_WAIT;
        end
        MISS_WAIT: begin
          if (bus.mem_resp_valid) begin
            valid[idx] <= 1'b1;
            state      <= LOOKUP;
          end
        end
        default: state <= IDLE;
      endcase
      // Placed last so a fence.i on the refill edge leaves the line invalid.
      if (bus.invalidate) valid <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && refill) begin
      data_q[idx] <= bus.mem_resp_data;
      tag_q[idx]  <= tag;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus random traffic against a behavioural model.
module tb_icache;

  logic clk = 1'b0;
  logic rst;
  icache_if bus();

  icache dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // memory responder knobs and bookkeeping (owned by the stimulus process)
  int          hold = 0;
  int          lat = 0;
  bit          inv_on_resp = 1'b0;
  bit          inv_next = 1'b0;
  int          n_hs = 0;
  logic [31:0] hs_addr = '0;
  bit          r_pend = 1'b0;
  int          r_cnt = 0;
  int          r_wait = 0;

  // behavioural model state (owned by the compare process)
  logic [3:0]  m_valid;
  logic [25:0] m_tag [4];
  bit          m_has_p, m_miss, m_asked;
  logic [31:0] m_p;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents: line 0x1000 is fixed, everything else is hashed from the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [27:0] ln;
    logic [1:0]  k;
    ln = a[31:4];
    k  = a[3:2];
    if (ln == 28'h100) return 32'h11111111 * (32'(k) + 32'd1);
    return (32'(ln) * 32'h9E3779B1) ^ (32'(k) * 32'h7F4A7C15) ^ 32'hA5A50000;
  endfunction

  function automatic logic [127:0] mem_line(input logic [31:0] a);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = mem_word({a[31:4], 4'(k*4)});
    return l;
  endfunction

  // Advance one clock; also plays the memory side (ready backpressure, latency, refill data).
  task automatic step();
    logic        hs, mv;
    logic [31:0] a;
    @(negedge clk);
    hs = bus.mem_req_valid && bus.mem_req_ready;
    mv = bus.mem_req_valid;
    a  = bus.mem_req_addr;
    @(posedge clk);
    #1;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
    bus.invalidate     = inv_next;
    inv_next           = 1'b0;
    if (hs) begin
      n_hs++;
      hs_addr = a;
      r_pend  = 1'b1;
      r_cnt   = lat;
    end
    if (r_pend) begin
      if (r_cnt == 0) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = mem_line(hs_addr);
        r_pend = 1'b0;
        if (inv_on_resp) begin
          bus.invalidate = 1'b1;
          inv_on_resp    = 1'b0;
        end
      end else begin
        r_cnt--;
      end
    end
    if (mv && !hs) r_wait++;
    else           r_wait = 0;
    bus.mem_req_ready = (r_wait >= hold);
  endtask

  // Issue one fetch, wait for its instruction; cyc = cycles from acceptance edge to response.
  task automatic fetch(input logic [31:0] a, input logic [31:0] exp, output int cyc);
    int n;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    n = 0;
    while (!bus.req_ready && n < 100) begin
      step();
      n++;
    end
    chk("fetch_ready", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 1'b0;
    cyc = 1;
    while (!bus.resp_valid && cyc < 100) begin
      step();
      cyc++;
    end
    chk("fetch_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("fetch_instr", bus.resp_instr, exp);
  endtask

  // Compare process: predicts the observable outputs each cycle, then advances the model.
  initial begin : compare
    bit          e_rr, e_rv, e_mv, hit_now;
    logic [31:0] e_ri, e_ma;
    int          li;
    m_valid = '0;
    m_has_p = 1'b0;
    m_miss  = 1'b0;
    m_asked = 1'b0;
    m_p     = '0;
    forever begin
      @(negedge clk);
      li      = int'(m_p[5:4]);
      hit_now = m_has_p && m_valid[li] && (m_tag[li] == m_p[31:6]);
      if (rst) begin
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_instr", bus.resp_instr, 32'd0);
        chk("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("rst_mem_req_addr", bus.mem_req_addr, 32'd0);
      end else begin
        e_rr = (!m_has_p && !m_miss) || hit_now;
        e_rv = hit_now;
        e_ri = mem_word(m_p);
        e_mv = m_miss && !m_asked;
        e_ma = {m_p[31:4], 4'b0};
        chk("req_ready", 32'(bus.req_ready), 32'(e_rr));
        chk("resp_valid", 32'(bus.resp_valid), 32'(e_rv));
        if (e_rv) chk("resp_instr", bus.resp_instr, e_ri);
        chk("mem_req_valid", 32'(bus.mem_req_valid), 32'(e_mv));
        if (e_mv) chk("mem_req_addr", bus.mem_req_addr, e_ma);
      end
      if (rst) begin
        m_has_p = 1'b0;
        m_miss  = 1'b0;
        m_asked = 1'b0;
        m_valid = '0;
      end else begin
        if (!m_has_p && !m_miss) begin
          if (bus.req_valid) begin
            m_has_p = 1'b1;
            m_p     = bus.req_addr;
          end
        end else if (m_has_p) begin
          if (hit_now) begin
            if (bus.req_valid) m_p = bus.req_addr;
            else               m_has_p = 1'b0;
          end else begin
            m_has_p = 1'b0;
            m_miss  = 1'b1;
            m_asked = 1'b0;
          end
        end else if (!m_asked) begin
          if (bus.mem_req_ready) m_asked = 1'b1;
        end else if (bus.mem_resp_valid) begin
          m_valid[li] = 1'b1;
          m_tag[li]   = m_p[31:6];
          m_miss      = 1'b0;
          m_has_p     = 1'b1;
        end
        if (bus.invalidate) m_valid = '0;
      end
    end
  end

  initial begin : stimulus
    int cyc, n0, n;
    bit acc;
    rst                = 1'b1;
    bus.req_valid      = 1'b0;
    bus.req_addr       = '0;
    bus.invalidate     = 1'b0;
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // cold miss at boot address, memory latency 2 extra cycles
    lat = 2;
    n0  = n_hs;
    fetch(32'h1000, 32'h11111111, cyc);
    chk("cold_miss_latency", 32'(cyc), 32'd6);
    chk("cold_miss_addr", hs_addr, 32'h1000);
    chk("cold_miss_reqs", 32'(n_hs - n0), 32'd1);

    // streaming hits on consecutive cycles
    lat = 0;
    n0  = n_hs;
    chk("stream_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h1004;
    step();
    bus.req_addr = 32'h1008;
    chk("stream_instr0", bus.resp_instr, 32'h22222222);
    step();
    bus.req_addr = 32'h100C;
    chk("stream_instr1", bus.resp_instr, 32'h33333333);
    step();
    bus.req_valid = 1'b0;
    chk("stream_instr2", bus.resp_instr, 32'h44444444);
    step();
    chk("stream_no_mem", 32'(n_hs - n0), 32'd0);

    // conflict eviction on index 0
    n0 = n_hs;
    fetch(32'h1040, mem_word(32'h1040), cyc);
    chk("evict_addr0", hs_addr, 32'h1040);
    fetch(32'h1000, 32'h11111111, cyc);
    chk("evict_addr1", hs_addr, 32'h1000);
    chk("evict_reqs", 32'(n_hs - n0), 32'd2);

    // memory backpressure: ready low for 5 cycles of MISS_REQ
    hold = 5;
    n0   = n_hs;
    fetch(32'h1048, mem_word(32'h1048), cyc);
    chk("backpressure_latency", 32'(cyc), 32'd9);
    chk("backpressure_reqs", 32'(n_hs - n0), 32'd1);
    hold = 0;

    // fence.i after caching, then fence.i coinciding with the refill
    fetch(32'h1000, 32'h11111111, cyc);
    fetch(32'h1004, 32'h22222222, cyc);
    chk("cached_hit_latency", 32'(cyc), 32'd1);
    inv_next = 1'b1;
    step();
    step();
    n0 = n_hs;
    fetch(32'h1000, 32'h11111111, cyc);
    chk("fence_refetch_latency", 32'(cyc), 32'd4);
    chk("fence_refetch_reqs", 32'(n_hs - n0), 32'd1);
    inv_next = 1'b1;
    step();
    step();
    inv_on_resp = 1'b1;
    n0 = n_hs;
    fetch(32'h1008, 32'h33333333, cyc);
    chk("fence_race_latency", 32'(cyc), 32'd7);
    chk("fence_race_reqs", 32'(n_hs - n0), 32'd2);

    // reset while waiting for a refill, then a stray response
    lat = 6;
    n0  = n_hs;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h3000;
    n = 0;
    while (n_hs == n0 && n < 50) begin
      step();
      n++;
    end
    chk("midrefill_handshake", 32'(n_hs - n0), 32'd1);
    bus.req_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    chk("post_reset_idle", 32'(bus.req_ready), 32'd1);
    repeat (8) step();
    lat = 0;
    n0  = n_hs;
    fetch(32'h2000, mem_word(32'h2000), cyc);
    chk("post_reset_miss_latency", 32'(cyc), 32'd4);
    chk("post_reset_miss_reqs", 32'(n_hs - n0), 32'd1);

    // random traffic; requests are held until accepted
    for (int i = 0; i < 600; i++) begin
      acc = bus.req_valid && bus.req_ready;
      hold = $urandom_range(0, 2);
      lat  = $urandom_range(0, 3);
      if ($urandom_range(0, 40) == 0) inv_next = 1'b1;
      if ($urandom_range(0, 12) == 0) inv_on_resp = 1'b1;
      step();
      rst = ($urandom_range(0, 250) == 0);
      if (acc || !bus.req_valid) begin
        bus.req_valid = ($urandom_range(0, 3) != 0);
        bus.req_addr  = 32'h0001_0000 * 32'($urandom_range(0, 2)) + 32'h1000
                      + 32'($urandom_range(0, 3)) * 32'd16 + 32'($urandom_range(0, 15));
      end
    end
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    repeat (12) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped instruction cache between the fetch stage (PC generator) and the instruction memory port.
- Geometry comes from the shared constants: ICLN lines of ICLLEN bits.
- On a hit, returns one ILEN-bit instruction one cycle after acceptance.
- On a miss, it runs a whole-line refill over a valid/ready request and valid-only response memory interface.

Parameters:
- ICLN, 4, number of cache lines (power of two).
- ICLLEN, 128, line length in bits (power-of-two multiple of ILEN).
- ILEN, 32, instruction width.
- XLEN, 32, address width.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  fetch request valid.
- req_addr  in  XLEN  fetch byte address.
- req_ready  out  1  cache can accept a request this cycle.
- resp_valid  out  1  resp_instr valid (consumer always accepts).
- resp_instr  out  ILEN  fetched instruction.
- invalidate  in  1  fence.i: clear all valid bits.
- mem_req_valid  out  1  line refill request.
- mem_req_addr  out  XLEN  line-aligned refill address.
- mem_req_ready  in  1  memory accepts request.
- mem_resp_valid  in  1  refill line valid (single beat).
- mem_resp_data  in  ICLLEN  refill line; word k is in bits [32k+31:32k].

Behaviour:
- Address split:
  - OFF = log2(ICLLEN/8) = 4 bits, [3:0].
  - IDX = log2(ICLN) = 2 bits, [5:4].
  - TAG = XLEN-6 = 26 bits, [31:6].
  - Word select is addr[3:2]; addr[1:0] is ignored.
- Storage: per line, a valid bit, a TAG register and an ICLLEN data register, all flops. Only valid bits are reset.
- States: IDLE, LOOKUP, MISS_REQ, MISS_WAIT.
- Reset (rst=1 at an edge):
  - state goes to IDLE and all valid bits are cleared.
  - While rst=1: req_ready=0, resp_valid=0, mem_req_valid=0, resp_instr=0, mem_req_addr=0.
- IDLE:
  - req_ready=1.
  - On req_valid, latch req_addr into pend_addr and go to LOOKUP.
- LOOKUP: hit = valid[idx] && tag[idx]==pend_addr.TAG.
  - On hit: resp_valid=1, resp_instr = selected word.
    - req_ready=1, so back-to-back hits give one instruction per cycle.
    - A new request accepted in this cycle reloads pend_addr and stays in LOOKUP; otherwise go to IDLE.
  - On miss: resp_valid=0, req_ready=0, go to MISS_REQ.
- MISS_REQ:
  - mem_req_valid=1 and mem_req_addr = {pend_addr[31:4], 4'b0}, both held stable until mem_req_ready.
  - On handshake, go to MISS_WAIT.
- MISS_WAIT:
  - On mem_resp_valid, write data and tag, set valid[idx], and go to LOOKUP.
  - The replay then hits, so miss latency is 3 cycles plus memory latency.
- Hit latency: request accepted at edge N gives resp_valid during cycle N+1.
- mem_resp_valid outside MISS_WAIT is ignored.
- invalidate (any state): clears all valid bits at the edge.
  - If it coincides with a refill write, invalidate wins and the line stays invalid.
  - The replay then misses and refetches; this is correct, not a deadlock.
  - invalidate in LOOKUP does not suppress that cycle's hit response.
- rst mid-refill: the request is abandoned, and a later stray mem_resp_valid is ignored.
- req_valid while req_ready=0 is not accepted; fetch holds it.

Decomposition:
- Add to constants_pkg:
  - ICOFF_W = $clog2(ICLLEN/8)
  - ICIDX_W = $clog2(ICLN)
  - ICTAG_W = XLEN-ICIDX_W-ICOFF_W
  - ICWORDS = ICLLEN/ILEN
  - typedef enum ic_state_t {IDLE, LOOKUP, MISS_REQ, MISS_WAIT}
- Single module; the arrays are small enough to stay inline, so no sub-module.

Test Plan:
1. Cold miss at BOOT_ADDR: req 0x1000 after reset.
   - Expect mem_req_addr=0x1000.
   - Respond with line 0x44444444_33333333_22222222_11111111.
   - Expect resp_instr=0x11111111 exactly 3 cycles + mem latency after acceptance.
2. Streaming hits: reqs 0x1004, 0x1008, 0x100C on consecutive cycles.
   - Expect 0x22222222, 0x33333333, 0x44444444 on consecutive cycles, with no mem_req.
3. Conflict eviction: req 0x1040 (idx 0, tag 0x41) then 0x1000.
   - Expect two refills (0x1040, 0x1000) and correct words each time.
4. Memory backpressure: hold mem_req_ready=0 for 5 cycles in MISS_REQ.
   - mem_req_valid and mem_req_addr stay stable, req_ready=0, and exactly one request is accepted.
5. fence.i: after line 0x1000 is cached, pulse invalidate, then req 0x1000.
   - Expect a fresh refill.
   - Also pulse invalidate on the same cycle as mem_resp_valid; expect a second refill for the same address.
6. Reset mid-refill: assert rst in MISS_WAIT, then drive a stray mem_resp_valid.
   - Expect all outputs 0 during reset, state IDLE afterwards, and req 0x2000 (EXCEPTION_ADDR) missing.
